// File: rtl/byte_striping_cond.sv
// byte_striping_cond: transmit-side byte striper.
// Splits one byte stream into two lanes. Each pair is presented together and
// held for two cycles. Bytes at even positions of a pair go to lane_0 and
// bytes at odd positions go to lane_1.
// Optional feature macro BYTE_STRIPING_PAD_EN: when defined, a partial pair
// fills lane_1 with PAD_BYTE and raises valid_1. When undefined, lane_1 is left
// empty (lane_1=0, valid_1=0).
module byte_striping_cond #(
  parameter int unsigned            DATA_W   = 8,
  parameter logic [DATA_W-1:0]      PAD_BYTE = DATA_W'(8'hBC)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_0,
  output logic              valid_1
);

`ifdef BYTE_STRIPING_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE       = 1'b0,
    HAVE_FIRST = 1'b1
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hold0_q;
  logic [DATA_W-1:0] lane_0_q;
  logic [DATA_W-1:0] lane_1_q;
  logic              valid_0_q;
  logic              valid_1_q;
  logic              hold_cnt_q;

  // Pair capture, lane load and two-cycle output hold
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold0_q    <= '0;
      lane_0_q   <= '0;
      lane_1_q   <= '0;
      valid_0_q  <= 1'b0;
      valid_1_q  <= 1'b0;
      hold_cnt_q <= 1'b0;
    end else if (state_q == HAVE_FIRST) begin
      // Every HAVE_FIRST cycle loads the lanes: a full pair or a flushed partial pair
      lane_0_q   <= hold0_q;
      valid_0_q  <= 1'b1;
      hold_cnt_q <= 1'b1;
      state_q    <= IDLE;
      if (valid_in) begin
        lane_1_q  <= data_in;
        valid_1_q <= 1'b1;
      end else begin
        lane_1_q  <= PAD_EN ? PAD_BYTE : '0;
        valid_1_q <= PAD_EN;
      end
    end else begin
      // IDLE: capture the first byte; the outputs count down their hold
      if (valid_in) begin
        hold0_q <= data_in;
        state_q <= HAVE_FIRST;
      end
      if (hold_cnt_q) begin
        hold_cnt_q <= 1'b0;
      end else begin
        lane_0_q  <= '0;
        lane_1_q  <= '0;
        valid_0_q <= 1'b0;
        valid_1_q <= 1'b0;
      end
    end
  end

  assign lane_0  = lane_0_q;
  assign lane_1  = lane_1_q;
  assign valid_0 = valid_0_q;
  assign valid_1 = valid_1_q;

endmodule

// File: tb/tb_byte_striping_cond.sv
// Bench for byte_striping_cond: directed lane checks plus an un-striper
// monitor that rebuilds the byte stream and compares it against a queue.
module tb_byte_striping_cond;

`ifdef BYTE_STRIPING_PAD_EN
  localparam logic [7:0] PART_L1 = 8'hBC;
  localparam logic       PART_V1 = 1'b1;
  localparam logic       PAD_ON  = 1'b1;
`else
  localparam logic [7:0] PART_L1 = 8'h00;
  localparam logic       PART_V1 = 1'b0;
  localparam logic       PAD_ON  = 1'b0;
`endif

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] lane_0;
  logic [7:0] lane_1;
  logic       valid_0;
  logic       valid_1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb_q[$];
  logic       mon_phase = 1'b0;

  byte_striping_cond dut (
    .clk_2f  (clk_2f),
    .reset   (reset),
    .data_in (data_in),
    .valid_in(valid_in),
    .lane_0  (lane_0),
    .lane_1  (lane_1),
    .valid_0 (valid_0),
    .valid_1 (valid_1)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [7:0] l0, input logic [7:0] l1,
                           input logic v0, input logic v1);
    chk({tag, ".lane_0"}, lane_0, l0);
    chk({tag, ".lane_1"}, lane_1, l1);
    chk({tag, ".valid_0"}, 8'(valid_0), 8'(v0));
    chk({tag, ".valid_1"}, 8'(valid_1), 8'(v1));
  endtask

  // Drive one cycle of input; outputs are looked at 1 time unit after the edge
  task automatic cyc(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    if (v) sb_q.push_back(d);
    @(posedge clk_2f);
    #1;
  endtask

  // Un-striper model: each valid_0 run is made of 2-cycle blocks, one pair per block
  always @(negedge clk_2f) begin
    if (!reset) begin
      mon_phase = 1'b0;
      sb_q.delete();
    end else if (valid_0) begin
      if (!mon_phase) begin
        if (sb_q.size() == 0) chk("mon.lane_0_unexpected", lane_0, 8'hxx);
        else                  chk("mon.lane_0", lane_0, sb_q.pop_front());
        if (valid_1 && !(PAD_ON && lane_1 == 8'hBC)) begin
          if (sb_q.size() == 0) chk("mon.lane_1_unexpected", lane_1, 8'hxx);
          else                  chk("mon.lane_1", lane_1, sb_q.pop_front());
        end
      end
      mon_phase = ~mon_phase;
    end else begin
      if (valid_1) chk("mon.valid_1_without_valid_0", 8'(valid_1), 8'h00);
      mon_phase = 1'b0;
    end
  end

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(posedge clk_2f); #1;
    @(posedge clk_2f); #1;
    chk_lanes("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;

    // T2: two back-to-back pairs stream gap-free
    cyc(1'b1, 8'h11);
    chk_lanes("t2.c0", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h22);
    chk_lanes("t2.c1", 8'h11, 8'h22, 1'b1, 1'b1);
    cyc(1'b1, 8'h33);
    chk_lanes("t2.c2", 8'h11, 8'h22, 1'b1, 1'b1);
    cyc(1'b1, 8'h44);
    chk_lanes("t2.c3", 8'h33, 8'h44, 1'b1, 1'b1);
    cyc(1'b0, 8'h00);
    chk_lanes("t2.c4", 8'h33, 8'h44, 1'b1, 1'b1);
    cyc(1'b0, 8'h00);
    chk_lanes("t2.c5", 8'h00, 8'h00, 1'b0, 1'b0);

    // T3: single byte then idle
    cyc(1'b1, 8'hA5);
    cyc(1'b0, 8'h00);
    chk_lanes("t3.c1", 8'hA5, PART_L1, 1'b1, PART_V1);
    cyc(1'b0, 8'h00);
    chk_lanes("t3.c2", 8'hA5, PART_L1, 1'b1, PART_V1);
    cyc(1'b0, 8'h00);
    chk_lanes("t3.c3", 8'h00, 8'h00, 1'b0, 1'b0);

    // T4: a gap in HAVE_FIRST flushes the partial pair, next byte realigns to lane_0
    cyc(1'b1, 8'h01);
    cyc(1'b0, 8'h00);
    chk_lanes("t4.c1", 8'h01, PART_L1, 1'b1, PART_V1);
    cyc(1'b1, 8'h02);
    chk_lanes("t4.c2", 8'h01, PART_L1, 1'b1, PART_V1);
    cyc(1'b1, 8'h03);
    chk_lanes("t4.c3", 8'h02, 8'h03, 1'b1, 1'b1);
    cyc(1'b0, 8'h00);
    chk_lanes("t4.c4", 8'h02, 8'h03, 1'b1, 1'b1);
    cyc(1'b0, 8'h00);
    chk_lanes("t4.c5", 8'h00, 8'h00, 1'b0, 1'b0);

    // T1: asynchronous reset in the middle of a displayed pair
    cyc(1'b1, 8'h55);
    cyc(1'b1, 8'h66);
    cyc(1'b1, 8'h77);
    chk_lanes("t1.pre", 8'h55, 8'h66, 1'b1, 1'b1);
    #1 reset = 1'b0;
    #1 chk_lanes("t1.async", 8'h00, 8'h00, 1'b0, 1'b0);
    valid_in = 1'b0;
    @(posedge clk_2f); #1;
    reset = 1'b1;
    sb_q.delete();
    cyc(1'b0, 8'h00);
    chk_lanes("t1.rel1", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    chk_lanes("t1.rel2", 8'h00, 8'h00, 1'b0, 1'b0);

    // T5: reset pulse while 7E sits in the capture register
    cyc(1'b1, 8'h7E);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    sb_q.delete();
    valid_in = 1'b0;
    @(posedge clk_2f); #1;
    chk_lanes("t5.c1", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00);
    chk_lanes("t5.c2", 8'h00, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h9A);
    cyc(1'b1, 8'h9B);
    chk_lanes("t5.c4", 8'h9A, 8'h9B, 1'b1, 1'b1);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    chk_lanes("t5.c6", 8'h00, 8'h00, 1'b0, 1'b0);

    // T6: random bytes with random gaps, rebuilt by the un-striper monitor
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 2) == 0) cyc(1'b0, 8'h00);
      cyc(1'b1, 8'($urandom_range(0, 8'hBB)));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00);
    chk("t6.queue_drained", 8'(sb_q.size()), 8'h00);
    chk_lanes("t6.idle", 8'h00, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
